div_arbiter: RTL
================

Name: div_arbiter

Overview:
- Sequences and shares the single iterative divider between two requesters: the Speed unit on port 0 and the Average_speed unit on port 1.
- Replaces the externally driven select/enable scheme with a request/done handshake per requester.
- Arbitrates round-robin, latches operands, starts the divider, and returns the result to the winner.
- Short-circuits divide-by-zero and guards against a hung divider with a watchdog.

Parameters:
- WIDTH, 16, operand/result width (matches divider DIV_WIDTH)
- TIMEOUT, 64, max cycles in WAIT before abort (≥ WIDTH+2)
- TO_W, 7, watchdog counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 (speed) request; held until done0
- dividend0  in  WIDTH  requester 0 dividend; stable while req0
- divisor0  in  WIDTH  requester 0 divisor; stable while req0
- req1  in  1  requester 1 (avg speed) request
- dividend1  in  WIDTH  requester 1 dividend
- divisor1  in  WIDTH  requester 1 divisor
- done0  out  1  one-cycle pulse, res0/err0 valid
- res0  out  WIDTH  quotient for requester 0, held until next done0
- err0  out  1  divide-by-zero or timeout for requester 0
- done1, res1, err1  out  1/WIDTH/1  same for requester 1
- div_start  out  1  one-cycle start pulse to divider
- div_dividend  out  WIDTH  latched dividend to divider
- div_divisor  out  WIDTH  latched divisor to divider
- div_busy  in  1  divider busy
- div_ready  in  1  divider result valid (single-cycle)
- div_res  in  WIDTH  divider quotient
- busy  out  1  arbiter not IDLE

Behaviour:
- Reset: every output 0, state IDLE, last_grant=1 (port 0 wins the first tie), watchdog=0. Reset mid-operation aborts silently with no done pulse; a late div_ready is ignored.
- States: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - If any req is high at edge k, latch winner index, dividend and divisor.
  - Tie → the port ≠ last_grant.
  - If the latched divisor is 0 → DELIVER with err=1, res={WIDTH{1'b1}}; the divider is never started.
  - Otherwise → ISSUE.
- ISSUE: div_start=1 for exactly this cycle; div_dividend/div_divisor driven from latches (stable IDLE→DELIVER); → WAIT; watchdog cleared.
- WAIT:
  - Watchdog increments each cycle.
  - div_ready=1 → capture div_res, err=0, → DELIVER.
  - Watchdog reaches TIMEOUT without div_ready → err=1, res=all ones, → DELIVER. A div_ready arriving in the same cycle as expiry wins (no error).
  - div_busy is informational only; a ready without a preceding busy is still accepted.
- DELIVER: done<winner>=1 for one cycle; res/err<winner> updated on the same edge that raises done; last_grant=winner; → IDLE.
- Latency:
  - req sampled at edge k → div_start high in cycle k+1.
  - done one cycle after the div_ready cycle.
  - Divide-by-zero: done in cycle k+1 (IDLE→DELIVER).
- Back-to-back: IDLE lasts ≥1 cycle between grants. A requester still holding req after its done is re-arbitrated normally, so round-robin interleaves with a pending other port.
- Requester drops req after grant: the operation completes and done still pulses; the requester ignores it. req changes while not in IDLE have no effect.
- res/err of the non-winning port never change.

Decomposition:
- Shared package: state encoding localparams (S_IDLE, S_ISSUE, S_WAIT, S_DELIVER), DIV_ZERO_RES constant, port index constants P_SPEED=0, P_AVG=1.
- One natural sub-module: rr_arb2, a 2-input round-robin grant with last_grant register (combinational grant, registered pointer update on DELIVER).
- Everything else lives in one FSM module.

Test Plan:
- Single request: req0, 1000/7, divider model ready after 17 cycles → div_start one cycle after req; done0 one cycle after ready; res0=142, err0=0; res1 unchanged.
- Simultaneous: req0 and req1 both high from reset release, 100/10 and 90/9 → port 0 served first (res0=10), then port 1 (res1=10); third tie with both still high → port 0 again.
- Divide-by-zero: req1, divisor 0 → done1 in cycle after sampling, res1=16'hFFFF, err1=1, div_start never asserted.
- Timeout: req0, divider never asserts ready → done0 exactly TIMEOUT cycles after entering WAIT (plus DELIVER), err0=1, res0=16'hFFFF; a subsequent req1 completes normally.
- Reset mid-WAIT: req0 issued, reset at cycle 5 of WAIT, divider ready arrives 3 cycles later → no done0, outputs 0, busy=0, next request starts cleanly.

Source files
------------

// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_e;

  // Requester port indices
  localparam logic P_SPEED = 1'b0;
  localparam logic P_AVG   = 1'b1;

  // Result reported on divide-by-zero or watchdog abort; sliced to WIDTH by users
  localparam int unsigned         MAX_WIDTH    = 64;
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_RES = '1;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester, divider and status signals of the divider arbiter.
interface div_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic [WIDTH-1:0] dividend0;
  logic [WIDTH-1:0] divisor0;
  logic             req1;
  logic [WIDTH-1:0] dividend1;
  logic [WIDTH-1:0] divisor1;
  logic             done0;
  logic [WIDTH-1:0] res0;
  logic             err0;
  logic             done1;
  logic [WIDTH-1:0] res1;
  logic             err1;
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_busy;
  logic             div_ready;
  logic [WIDTH-1:0] div_res;
  logic             busy;

  // Arbiter view
  modport slave (
    input  req0, dividend0, divisor0, req1, dividend1, divisor1,
    input  div_busy, div_ready, div_res,
    output done0, res0, err0, done1, res1, err1,
    output div_start, div_dividend, div_divisor, busy
  );

  // Requesters/divider view
  modport master (
    output req0, dividend0, divisor0, req1, dividend1, divisor1,
    output div_busy, div_ready, div_res,
    input  done0, res0, err0, done1, res1, err1,
    input  div_start, div_dividend, div_divisor, busy
  );

endinterface

// File: rtl/div_arbiter_rr_arb2.sv
// Two-input round-robin grant: combinational winner, registered last-grant pointer.
module div_arbiter_rr_arb2
  import div_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       update_idx_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  logic last_q, last_d;

  // Winner selection: a tie goes to the port that was not granted last
  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = P_SPEED;
    if (req_i[0] && req_i[1]) begin
      grant_idx_o = ~last_q;
    end else if (req_i[1]) begin
      grant_idx_o = P_AVG;
    end
    last_d = update_i ? update_idx_i : last_q;
  end

  // Pointer starts at port 1 so port 0 wins the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= P_AVG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between the speed (port 0) and average-speed
// (port 1) units with a request/done handshake, divide-by-zero bypass and a
// watchdog on the divider.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input logic          clock,
  input logic          reset,
  div_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             idx_q, idx_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
  logic             err0_q, err0_d, err1_q, err1_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_err;
  logic             grant_valid;
  logic             grant_idx;
  logic [WIDTH-1:0] sel_divisor;
  logic             unused_div_busy;

  // div_busy carries no control meaning; a ready without busy is accepted
  assign unused_div_busy = bus.div_busy;

  div_arbiter_rr_arb2 u_arb (
    .clk_i        (clock),
    .rst_i        (reset),
    .req_i        ({bus.req1, bus.req0}),
    .update_i     (state_q == S_DELIVER),
    .update_idx_i (idx_q),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

  // Next-state logic; the winner's result is written on the edge entering DELIVER
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    wd_d        = wd_q;
    wr_en       = 1'b0;
    wr_res      = '0;
    wr_err      = 1'b0;
    sel_divisor = (grant_idx == P_AVG) ? bus.divisor1 : bus.divisor0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          idx_d      = grant_idx;
          dividend_d = (grant_idx == P_AVG) ? bus.dividend1 : bus.dividend0;
          divisor_d  = sel_divisor;
          if (sel_divisor == '0) begin
            wr_en   = 1'b1;
            wr_res  = DIV_ZERO_RES[WIDTH-1:0];
            wr_err  = 1'b1;
            state_d = S_DELIVER;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + TO_W'(1);
        // ready in the expiry cycle takes priority over the abort
        if (bus.div_ready) begin
          wr_en   = 1'b1;
          wr_res  = bus.div_res;
          state_d = S_DELIVER;
        end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
          wr_en   = 1'b1;
          wr_res  = DIV_ZERO_RES[WIDTH-1:0];
          wr_err  = 1'b1;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    res0_d = res0_q;
    err0_d = err0_q;
    res1_d = res1_q;
    err1_d = err1_q;
    if (wr_en && (idx_d == P_SPEED)) begin
      res0_d = wr_res;
      err0_d = wr_err;
    end
    if (wr_en && (idx_d == P_AVG)) begin
      res1_d = wr_res;
      err1_d = wr_err;
    end
  end

  // State, operand latches, watchdog and per-port results
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= P_SPEED;
      dividend_q <= '0;
      divisor_q  <= '0;
      wd_q       <= '0;
      res0_q     <= '0;
      err0_q     <= 1'b0;
      res1_q     <= '0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      wd_q       <= wd_d;
      res0_q     <= res0_d;
      err0_q     <= err0_d;
      res1_q     <= res1_d;
      err1_q     <= err1_d;
    end
  end

  assign bus.div_start    = (state_q == S_ISSUE);
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done0        = (state_q == S_DELIVER) && (idx_q == P_SPEED);
  assign bus.done1        = (state_q == S_DELIVER) && (idx_q == P_AVG);
  assign bus.res0         = res0_q;
  assign bus.err0         = err0_q;
  assign bus.res1         = res1_q;
  assign bus.err1         = err1_q;

endmodule
